cache_controller: RTL and testbench

- Miss-handling FSM that sits directly upstream of the 64-line direct-mapped cache array (11-bit line address, 5-bit tag, 64-bit line of 4×16-bit words).
- Accepts word-granular CPU load/store requests and drives the cache array's re/we/addr/wr_data/wdirty.
- On a miss it writes back the dirty victim, then fetches the new line from multi-cycle unified memory.
- One instance per core (I-side or D-side); also carries hit/miss performance counters.

---
 rtl/cache_controller.sv | 125 ++++++++++++
 tb/tb_cache_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped cache miss handler (victim write-back, line fetch, fill)
// with saturating hit/miss counters.
module cache_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      cpu_addr,
    input  logic             cpu_re,
    input  logic             cpu_we,
    input  logic [15:0]      cpu_wdata,
    output logic [15:0]      cpu_rdata,
    output logic             cpu_rdy,
    output logic [10:0]      c_addr,
    output logic [63:0]      c_wr_data,
    output logic             c_wdirty,
    output logic             c_we,
    output logic             c_re,
    input  logic [63:0]      c_rd_data,
    input  logic [4:0]       c_tag_out,
    input  logic             c_hit,
    input  logic             c_dirty,
    output logic [10:0]      mem_addr,
    output logic [63:0]      mem_wdata,
    output logic             mem_re,
    output logic             mem_we,
    input  logic [63:0]      mem_rdata,
    input  logic             mem_rdy,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    typedef enum logic [1:0] {IDLE, EVICT, ALLOC, FILL} state_t;
    state_t           state_q, state_d;
    logic [10:0]      vict_addr_q, vict_addr_d;
    logic [63:0]      vict_line_q, vict_line_d, fill_q, fill_d, merged;
    logic             retry_q, retry_d, req;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic             unused_addr;
    assign unused_addr = ^cpu_addr[15:13];
    assign req         = cpu_re | cpu_we;
    assign c_addr      = cpu_addr[12:2];
    assign hit_cnt     = hit_cnt_q;
    assign miss_cnt    = miss_cnt_q;
    always_comb begin
        merged = c_rd_data;
        merged[{cpu_addr[1:0], 4'd0} +: 16] = cpu_wdata;
    end
    always_comb begin
        state_d     = state_q;
        vict_addr_d = vict_addr_q;
        vict_line_d = vict_line_q;
        fill_d      = fill_q;
        retry_d     = retry_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        cpu_rdata   = 16'h0;
        cpu_rdy     = 1'b0;
        c_wr_data   = 64'h0;
        c_wdirty    = 1'b0;
        c_we        = 1'b0;
        c_re        = 1'b0;
        mem_addr    = 11'h0;
        mem_wdata   = 64'h0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        unique case (state_q)
            IDLE: if (req) begin
                c_re      = 1'b1;
                c_wdirty  = 1'b1;
                c_wr_data = merged;
                if (c_hit) begin
                    c_we      = cpu_we;
                    cpu_rdy   = 1'b1;
                    cpu_rdata = c_rd_data[{cpu_addr[1:0], 4'd0} +: 16];
                    retry_d   = 1'b0;
                    // the retry after a fill is the tail of a miss, not a hit
                    hit_cnt_d = (!retry_q && hit_cnt_q != '1) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
                end else begin
                    vict_line_d = c_rd_data;
                    vict_addr_d = {c_tag_out, cpu_addr[7:2]};
                    state_d     = c_dirty ? EVICT : ALLOC;
                    miss_cnt_d  = (miss_cnt_q != '1) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
                end
            end
            EVICT: begin
                mem_we    = 1'b1;
                mem_addr  = vict_addr_q;
                mem_wdata = vict_line_q;
                state_d   = mem_rdy ? ALLOC : EVICT;
            end
            ALLOC: begin
                mem_re   = 1'b1;
                mem_addr = cpu_addr[12:2];
                fill_d   = mem_rdy ? mem_rdata : fill_q;
                state_d  = mem_rdy ? FILL : ALLOC;
            end
            FILL: begin
                c_we      = 1'b1;
                c_wr_data = fill_q;
                retry_d   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vict_addr_q <= 11'h0;
            vict_line_q <= 64'h0;
            fill_q      <= 64'h0;
            retry_q     <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            vict_addr_q <= vict_addr_d;
            vict_line_q <= vict_line_d;
            fill_q      <= fill_d;
            retry_q     <= retry_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: cache array and latency memory around the controller, checked against
// a word-image / residency reference model; a CNT_W=2 twin exercises counter saturation.
module tb_cache_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_re = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_rdata, hit_cnt, miss_cnt;
    logic        cpu_rdy, c_wdirty, c_we, c_re, c_hit, c_dirty, mem_re, mem_we, mem_rdy;
    logic [10:0] c_addr, mem_addr;
    logic [63:0] c_wr_data, c_rd_data, mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic [4:0]  c_tag_out;
    logic [15:0] cpu_rdata2;
    logic        cpu_rdy2, c_wdirty2, c_we2, c_re2, mem_re2, mem_we2;
    logic [10:0] c_addr2, mem_addr2;
    logic [63:0] c_wr_data2, mem_wdata2;
    logic [1:0]  hit2, miss2;
    logic        unused_twin;
    always #5 clk = ~clk;

    cache_controller #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy), .c_addr(c_addr),
        .c_wr_data(c_wr_data), .c_wdirty(c_wdirty), .c_we(c_we), .c_re(c_re),
        .c_rd_data(c_rd_data), .c_tag_out(c_tag_out), .c_hit(c_hit), .c_dirty(c_dirty),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

    // twin sees identical inputs, so it walks the same path with 2-bit counters
    cache_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata2), .cpu_rdy(cpu_rdy2), .c_addr(c_addr2),
        .c_wr_data(c_wr_data2), .c_wdirty(c_wdirty2), .c_we(c_we2), .c_re(c_re2),
        .c_rd_data(c_rd_data), .c_tag_out(c_tag_out), .c_hit(c_hit), .c_dirty(c_dirty),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_re(mem_re2), .mem_we(mem_we2),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .hit_cnt(hit2), .miss_cnt(miss2));
    assign unused_twin = ^{cpu_rdata2, cpu_rdy2, c_wdirty2, c_we2, c_re2, mem_re2, mem_we2,
                           c_addr2, mem_addr2, c_wr_data2, mem_wdata2};

    logic [63:0] cd [64] = '{default: 64'h0};
    logic [4:0]  ct [64] = '{default: 5'h0};
    logic        cv [64] = '{default: 1'b0};
    logic        cdy [64] = '{default: 1'b0};
    logic [5:0]  ci;
    assign ci        = c_addr[5:0];
    assign c_rd_data = cd[ci];
    assign c_tag_out = ct[ci];
    assign c_hit     = cv[ci] && ct[ci] == c_addr[10:6];
    assign c_dirty   = cv[ci] && cdy[ci];
    always @(posedge clk) if (c_we) begin
        cd[ci]  <= c_wr_data;
        ct[ci]  <= c_addr[10:6];
        cv[ci]  <= 1'b1;
        cdy[ci] <= c_wdirty;
    end

    function automatic logic [63:0] pat(input logic [10:0] l);
        return {l, 5'h1, l, 5'h2, l, 5'h3, l, 5'h4} ^ 64'h0123_4567_89ab_cdef;
    endfunction

    logic [63:0] mem [2048];
    logic        mw [2048] = '{default: 1'b0};
    int          lat = 4;
    bit          mem_en = 1'b1;
    int          mcnt = 0;
    logic        mrdy = 1'b0, stray = 1'b0;
    assign mem_rdy = mrdy | stray;
    // mem_rdy lands in the lat-th cycle that a request is held
    always @(posedge clk) begin
        mrdy <= 1'b0;
        if (!mem_en || !(mem_re || mem_we) || mrdy) mcnt <= 0;
        else if (mcnt == lat - 2) begin
            mrdy <= 1'b1;
            mcnt <= 0;
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                mw[mem_addr]  <= 1'b1;
            end else mem_rdata <= mw[mem_addr] ? mem[mem_addr] : pat(mem_addr);
        end else mcnt <= mcnt + 1;
    end

    logic [15:0] img [int];
    int          rtag [64] = '{default: -1};
    bit          rdirty [64] = '{default: 1'b0};
    int          tests = 0, fails = 0, eh = 0, em = 0;

    function automatic logic [15:0] ref_word(input int line, input int w);
        logic [63:0] p;
        p = pat(11'(line));
        return img.exists(line * 4 + w) ? img[line * 4 + w] : p[16 * w +: 16];
    endfunction

    function automatic logic [63:0] ref_line(input int line);
        logic [63:0] l;
        for (int w = 0; w < 4; w++) l[16 * w +: 16] = ref_word(line, w);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input bit we, input bit re, input logic [15:0] a, input logic [15:0] wd);
        int line, idx, w, exp_cyc, n, fills, both;
        bit hit, dirty, done, saw_we, saw_re;
        logic [10:0] wb_a, rd_a;
        logic [63:0] wb_d, cwr, old_vict, exp_line;
        logic [15:0] rdata;
        logic cwe, cwd;
        line = int'(a[12:2]);
        idx = line % 64;
        w = int'(a[1:0]);
        hit = rtag[idx] == line;
        dirty = !hit && rtag[idx] >= 0 && rdirty[idx];
        exp_cyc = hit ? 1 : dirty ? 2 * lat + 3 : lat + 3;
        old_vict = dirty ? ref_line(rtag[idx]) : 64'h0;
        n = 0; fills = 0; both = 0; done = 0; saw_we = 0; saw_re = 0;
        wb_a = '0; rd_a = '0; wb_d = '0; cwr = '0; rdata = '0; cwe = 0; cwd = 0;
        @(posedge clk);
        #1;
        cpu_addr = a; cpu_we = we; cpu_re = re; cpu_wdata = wd;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (mem_re && mem_we) both++;
            if (mem_we) begin saw_we = 1; wb_a = mem_addr; wb_d = mem_wdata; end
            if (mem_re) begin saw_re = 1; rd_a = mem_addr; end
            if (c_we && !c_wdirty) fills++;
            if (cpu_rdy) begin
                done = 1; rdata = cpu_rdata; cwe = c_we; cwd = c_wdirty; cwr = c_wr_data;
            end
        end
        @(posedge clk);
        #1;
        cpu_re = 0; cpu_we = 0;
        chk("rdy_seen", 64'(done), 64'd1);
        chk("latency", 64'(n), 64'(exp_cyc));
        if (!we) chk("rdata", rdata, ref_word(line, w));
        else begin
            exp_line = ref_line(line);
            exp_line[16 * w +: 16] = wd;
            chk("store_we_dirty", {cwe, cwd}, 2'b11);
            chk("store_line", cwr, exp_line);
        end
        chk("evict_seen", 64'(saw_we), 64'(dirty));
        if (dirty) begin
            chk("evict_addr", wb_a, 64'(rtag[idx]));
            chk("evict_data", wb_d, old_vict);
        end
        chk("fetch_seen", 64'(saw_re), 64'(!hit));
        if (!hit) chk("fetch_addr", rd_a, 64'(line));
        chk("fill_count", 64'(fills), 64'(!hit));
        chk("mem_excl", 64'(both), 64'd0);
        if (!hit) begin rtag[idx] = line; rdirty[idx] = 0; em++; end
        else eh++;
        if (we) begin img[line * 4 + w] = wd; rdirty[idx] = 1; end
        chk("hit_cnt", hit_cnt, 64'(eh));
        chk("miss_cnt", miss_cnt, 64'(em));
        chk("hit_sat", hit2, 64'(eh > 3 ? 3 : eh));
        chk("miss_sat", miss2, 64'(em > 3 ? 3 : em));
    endtask

    initial begin
        bit we;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {cpu_rdy, c_re, c_we, c_wdirty, mem_re, mem_we}, 64'h0);
        chk("rst_cnt", {hit_cnt, miss_cnt, hit2, miss2}, 64'h0);
        chk("rst_addr", {c_addr, mem_addr, cpu_rdata}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat = 4;
        req(0, 1, 16'h0005, 16'h0);
        req(0, 1, 16'h0006, 16'h0);
        req(1, 0, 16'h0004, 16'hBEEF);
        req(0, 1, 16'h0104, 16'h0);
        lat = 6;
        @(posedge clk);
        #1;
        cpu_addr = 16'h0200; cpu_re = 1'b1;
        repeat (3) @(negedge clk);
        chk("alloc_active", {mem_re, mem_addr}, {1'b1, 11'h080});
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_alloc", {mem_re, mem_we, cpu_rdy, c_we}, 64'h0);
        chk("rst_mid_cnt", {hit_cnt, miss_cnt}, 64'h0);
        cpu_re = 1'b0;
        mem_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stray = 1'b1;
        @(negedge clk);
        chk("stray_rdy", {c_we, mem_re, mem_we, cpu_rdy}, 64'h0);
        @(posedge clk);
        #1;
        stray = 1'b0;
        @(negedge clk);
        chk("stray_after", {c_we, mem_re, mem_we, cpu_rdy}, 64'h0);
        mem_en = 1'b1;
        eh = 0;
        em = 0;
        lat = 3;
        repeat (5) req(0, 1, 16'h0105, 16'h0);
        req(0, 1, 16'h0200, 16'h0);
        req(0, 1, 16'h0300, 16'h0);
        req(0, 1, 16'h0400, 16'h0);
        repeat (300) begin
            lat = $urandom_range(2, 6);
            we = 1'($urandom);
            req(we, we ? 1'($urandom) : 1'b1,
                {3'($urandom), 5'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'($urandom)},
                16'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
